// File: rtl/ysyx_22051013_mem_arb.sv
// Shares one bus-attached memory port between instruction fetch and load/store.
// One outstanding transaction; LS has priority, with a starvation guard for IF.
module ysyx_22051013_mem_arb #(
    parameter int unsigned AW         = 64,
    parameter int unsigned DW         = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [AW-1:0]   if_addr,
    output logic            if_resp_valid,
    output logic [DW-1:0]   if_rdata,

    input  logic            ls_req_valid,
    output logic            ls_req_ready,
    input  logic [AW-1:0]   ls_addr,
    input  logic            ls_wen,
    input  logic [DW-1:0]   ls_wdata,
    input  logic [DW/8-1:0] ls_wmask,
    output logic            ls_resp_valid,
    output logic [DW-1:0]   ls_rdata,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_rdata,

    output logic            arb_busy,
    output logic            arb_owner
);
    localparam int unsigned MW = DW / 8;
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wen_q, wen_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [MW-1:0] wmask_q, wmask_d;

    // Next-state, grant and handshake decode
    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        if_resp_valid = 1'b0;
        ls_resp_valid = 1'b0;

        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (ls_req_valid && !(if_req_valid && starve_q == CW'(STARVE_MAX))) begin
                        ls_req_ready = 1'b1;
                        owner_d      = 1'b1;
                        addr_d       = ls_addr;
                        wen_d        = ls_wen;
                        wdata_d      = ls_wdata;
                        wmask_d      = ls_wmask;
                        state_d      = S_REQ;
                        // A contested LS win only happens below STARVE_MAX, so this saturates
                        if (if_req_valid) begin
                            starve_d = starve_q + CW'(1);
                        end
                    end else if (if_req_valid) begin
                        if_req_ready = 1'b1;
                        owner_d      = 1'b0;
                        addr_d       = if_addr;
                        wen_d        = 1'b0;
                        wdata_d      = '0;
                        wmask_d      = '0;
                        starve_d     = '0;
                        state_d      = S_REQ;
                    end
                end
                S_REQ: begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        if (owner_q) begin
                            ls_resp_valid = 1'b1;
                        end else begin
                            if_resp_valid = 1'b1;
                        end
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign arb_busy  = (state_q != S_IDLE);
    assign arb_owner = owner_q;
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;

endmodule

// File: doc/ysyx_22051013_mem_arb.md
Name: ysyx_22051013_mem_arb

Overview:
- Arbitrates one shared memory port between instruction fetch (IF) and load/store (LS) once the core moves to a multi-cycle, bus-attached memory.
- Accepts one request at a time from either requester and registers it onto the memory port.
- Waits for the single response and routes it back to the owner.
- Priority is fixed with LS first; a starvation counter forces an IF grant after STARVE_MAX consecutive contested LS wins.

Parameters:
- AW, 64, address width
- DW, 64, data width
- STARVE_MAX, 4, number of consecutive contested LS grants before IF is forced (must be ≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  IF request
- if_req_ready  out  1  IF request accepted this cycle
- if_addr  in  AW  IF address (read only)
- if_resp_valid  out  1  IF response
- if_rdata  out  DW  IF read data
- ls_req_valid  in  1  LS request
- ls_req_ready  out  1  LS request accepted this cycle
- ls_addr  in  AW  LS address
- ls_wen  in  1  1 = write
- ls_wdata  in  DW  write data
- ls_wmask  in  DW/8  byte write mask
- ls_resp_valid  out  1  LS response (read data, or write ack)
- ls_rdata  out  DW  LS read data
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  AW  registered address
- mem_wen  out  1  registered write enable
- mem_wdata  out  DW  registered write data
- mem_wmask  out  DW/8  registered mask
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DW  memory read data
- arb_busy  out  1  1 whenever state != IDLE
- arb_owner  out  1  owner of current transaction (0 = IF, 1 = LS)

Behaviour:

Reset (rst high at a clk edge, including mid-transaction):
- state = IDLE, starve_cnt = 0, arb_owner = 0.
- mem_addr, mem_wen, mem_wdata and mem_wmask registers = 0.
- Any in-flight transaction is dropped; the memory side is reset by the same rst.
- All valid/ready outputs are 0 while rst is high.

State machine IDLE -> REQ -> WAIT -> IDLE:

IDLE:
- Winner selection:
  - Only one requester valid: that requester wins.
  - Both valid: LS wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
- The winner's *_req_ready is 1 combinationally in the same cycle; the loser's is 0.
- With no request, both readys are 0 and the state stays IDLE.
- On grant:
  - Latch addr/wen/wdata/wmask into the mem_* registers; for an IF grant, latch wen = 0, wdata = 0, wmask = 0.
  - Set arb_owner and go to REQ.

starve_cnt (updated on grant only):
- LS grant with if_req_valid also high: increment, saturating at STARVE_MAX.
- Any IF grant: clear to 0.
- LS grant with IF idle: hold.

REQ:
- mem_req_valid = 1 with the mem_* fields held stable.
- On mem_req_ready = 1, go to WAIT.
- No new requests are accepted; both *_req_ready are 0.

WAIT:
- mem_req_valid = 0.
- On mem_resp_valid = 1:
  - Assert the owner's *_resp_valid in the same cycle (combinational).
  - *_rdata = mem_rdata.
  - Go to IDLE.
- mem_resp_valid outside WAIT is ignored; it is never forwarded.

Data outputs:
- if_rdata and ls_rdata are always driven with mem_rdata.
- Only the matching resp_valid qualifies them.

Latency:
- Request is accepted in cycle N.
- mem_req_valid is first high in N+1.
- With mem_req_ready = 1 in N+1 and mem_resp_valid = 1 in N+2, the owner response is in N+2.
- The next grant is possible in N+3.

Single outstanding transaction:
- Requesters may hold *_req_valid high through a response.
- The arbiter re-arbitrates only in IDLE.

Test Plan:
- Reset mid-WAIT: LS read granted, mem_req_ready = 1, rst pulsed before the response -> next cycle all valids/readys 0, arb_busy 0, starve_cnt 0; a later mem_resp_valid produces no ls_resp_valid.
- Single IF read: if_addr = 0x80000000, memory ready immediately and responds one cycle later with 0x00000413 -> if_req_ready in cycle 0, mem_req_valid in cycle 1 with mem_addr = 0x80000000 and mem_wen = 0, if_resp_valid in cycle 2 with if_rdata = 0x00000413, ls_resp_valid stays 0.
- Simultaneous IF + LS with STARVE_MAX = 4, both held valid continuously -> grant order LS, LS, LS, LS, IF, LS…; starve_cnt reads 1, 2, 3, 4, 0.
- LS write: ls_addr = 0x80001000, wdata = 0x1122334455667788, wmask = 0x0F, mem_req_ready held low for 3 cycles -> mem_req_valid high 4 cycles with stable fields; ls_resp_valid on the ack.
- Memory asserts mem_resp_valid during IDLE and during REQ -> no *_resp_valid; state unaffected.
- LS back-to-back with IF idle -> starve_cnt stays 0; there is a one-IDLE-cycle gap between transactions.
